// File: rtl/link_pkg.sv
// link_pkg: shared link-word layout and assembler FSM encoding
package link_pkg;
    localparam int LINK_W     = 5;
    localparam int STROBE_BIT = 4;
    localparam int NIBBLE_W   = 4;
    typedef enum logic {ST_LOW, ST_HIGH} state_e;
endpackage

// File: rtl/sync_fwft_fifo.sv
// sync_fwft_fifo: synchronous first-word-fall-through FIFO
// Ports: clk/rst (sync, active-high), push_i/data_i write side,
// pop_i/data_o read side (data_o is the head, 0 when empty),
// full_o/empty_o status, count_o exact occupancy 0..DEPTH.
module sync_fwft_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push_i,
    input  logic [W-1:0]                 data_i,
    input  logic                         pop_i,
    output logic [W-1:0]                 data_o,
    output logic                         full_o,
    output logic                         empty_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [CW-1:0] cnt_q;
    logic          do_push, do_pop;
    assign empty_o = cnt_q == '0;
    assign full_o  = cnt_q == CW'(DEPTH);
    assign do_pop  = pop_i & ~empty_o;
    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign do_push = push_i & (~full_o | do_pop);
    assign data_o  = empty_o ? '0 : mem_q[rd_q];
    assign count_o = cnt_q;
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= data_i;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + 1'b1;
            if (do_pop) rd_q <= rd_q + 1'b1;
            cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
        end
    end
endmodule

// File: rtl/nibble_byte_assembler.sv
// nibble_byte_assembler: pairs strobed nibbles into bytes and queues them
// Ports: clk/rst (sync, active-high); rx_word {strobe, nibble} in;
// byte_data/byte_valid/byte_ready out handshake; fifo_count occupancy;
// overflow sticky drop flag; align_error one-cycle timeout pulse.
module nibble_byte_assembler
    import link_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 15
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [LINK_W-1:0]           rx_word,
    output logic [2*NIBBLE_W-1:0]       byte_data,
    output logic                        byte_valid,
    input  logic                        byte_ready,
    output logic [$clog2(DEPTH+1)-1:0]  fifo_count,
    output logic                        overflow,
    output logic                        align_error
);
    state_e              state_q, state_d;
    logic [NIBBLE_W-1:0] lo_q, lo_d;
    logic [7:0]          gap_q, gap_d;
    logic                overflow_q, align_q;
    logic                strobe, push, pop, timeout, full, empty;
    logic [NIBBLE_W-1:0] nib;
    assign strobe = rx_word[STROBE_BIT];
    assign nib    = rx_word[NIBBLE_W-1:0];
    assign pop    = byte_valid & byte_ready;
    always_comb begin
        state_d = state_q;
        lo_d    = lo_q;
        gap_d   = gap_q;
        push    = 1'b0;
        timeout = 1'b0;
        if (state_q == ST_LOW) begin
            if (strobe) begin
                lo_d    = nib;
                gap_d   = '0;
                state_d = ST_HIGH;
            end
        end else if (strobe) begin
            // A strobe on the would-be timeout cycle still completes the byte.
            push    = 1'b1;
            state_d = ST_LOW;
        end else if (gap_q == 8'(TIMEOUT - 1)) begin
            timeout = 1'b1;
            gap_d   = '0;
            state_d = ST_LOW;
        end else begin
            gap_d = gap_q + 1'b1;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_LOW;
            lo_q       <= '0;
            gap_q      <= '0;
            overflow_q <= 1'b0;
            align_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            lo_q       <= lo_d;
            gap_q      <= gap_d;
            overflow_q <= overflow_q | (push & full & ~pop);
            align_q    <= timeout;
        end
    end
    sync_fwft_fifo #(.W(2*NIBBLE_W), .DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .data_i  ({nib, lo_q}),
        .pop_i   (pop),
        .data_o  (byte_data),
        .full_o  (full),
        .empty_o (empty),
        .count_o (fifo_count)
    );
    assign byte_valid  = ~empty;
    assign overflow    = overflow_q;
    assign align_error = align_q;
endmodule

// File: tb/tb_nibble_byte_assembler.sv
// tb_nibble_byte_assembler: directed and random checks against a queue-based model
module tb_nibble_byte_assembler;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 15;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] rx_word = '0;
    logic       byte_ready = 1'b0;
    logic [7:0] byte_data;
    logic       byte_valid;
    logic [2:0] fifo_count;
    logic       overflow;
    logic       align_error;
    int checks = 0;
    int failures = 0;
    // Reference model: bytes waiting, plus the held low nibble and its age.
    logic [7:0] q[$];
    bit         pend;
    logic [3:0] lo;
    int         idle;
    bit         m_ovf, m_align;

    nibble_byte_assembler #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_word     (rx_word),
        .byte_data   (byte_data),
        .byte_valid  (byte_valid),
        .byte_ready  (byte_ready),
        .fifo_count  (fifo_count),
        .overflow    (overflow),
        .align_error (align_error)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model(input logic [4:0] w, input logic r, input logic rs);
        bit       pop, have;
        logic [7:0] b;
        m_align = 0;
        if (rs) begin
            q.delete();
            pend = 0;
            idle = 0;
            m_ovf = 0;
            return;
        end
        pop = (q.size() != 0) && r;
        have = 0;
        if (w[4]) begin
            if (pend) begin
                b = {w[3:0], lo};
                have = 1;
                pend = 0;
            end else begin
                pend = 1;
                lo = w[3:0];
                idle = 0;
            end
        end else if (pend) begin
            idle++;
            if (idle == TIMEOUT) begin
                pend = 0;
                m_align = 1;
            end
        end
        if (pop) void'(q.pop_front());
        if (have) begin
            if (q.size() < DEPTH) q.push_back(b);
            else m_ovf = 1;
        end
    endtask

    task automatic step(input logic [4:0] w, input logic r, input logic rs = 1'b0);
        rx_word = w;
        byte_ready = r;
        rst = rs;
        @(posedge clk);
        model(w, r, rs);
        #1;
        check("valid", int'(byte_valid), int'(q.size() != 0));
        check("count", int'(fifo_count), q.size());
        check("overflow", int'(overflow), int'(m_ovf));
        check("align", int'(align_error), int'(m_align));
        if (q.size() != 0) check("data", int'(byte_data), int'(q[0]));
    endtask

    initial begin
        // Reset
        step(5'h00, 1'b0, 1'b1);
        step(5'h00, 1'b0, 1'b1);
        check("rst_data", int'(byte_data), 0);
        check("rst_valid", int'(byte_valid), 0);
        // Basic pairing
        step(5'h13, 1'b1);
        step(5'h1A, 1'b1);
        check("pair_data", int'(byte_data), 8'hA3);
        check("pair_count", int'(fifo_count), 1);
        step(5'h00, 1'b1);
        check("pair_drain", int'(fifo_count), 0);
        // Strobe-low word ignored
        step(5'h15, 1'b0);
        step(5'h07, 1'b0);
        step(5'h1C, 1'b0);
        check("ign_data", int'(byte_data), 8'hC5);
        step(5'h00, 1'b1);
        // Timeout
        step(5'h11, 1'b1);
        for (int i = 0; i < TIMEOUT; i++) step(5'h00, 1'b1);
        check("to_pulse", int'(align_error), 1);
        step(5'h00, 1'b1);
        check("to_clear", int'(align_error), 0);
        step(5'h12, 1'b0);
        step(5'h13, 1'b0);
        check("realign", int'(byte_data), 8'h32);
        step(5'h00, 1'b1);
        // Strobe on the boundary cycle
        step(5'h14, 1'b0);
        for (int i = 0; i < TIMEOUT - 1; i++) step(5'h00, 1'b0);
        step(5'h19, 1'b0);
        check("bound_data", int'(byte_data), 8'h94);
        check("bound_align", int'(align_error), 0);
        step(5'h00, 1'b1);
        // Overflow
        for (int i = 1; i <= 5; i++) begin
            step(5'h11 + 5'(i - 1), 1'b0);
            step(5'h10, 1'b0);
        end
        check("ovf_count", int'(fifo_count), 4);
        check("ovf_flag", int'(overflow), 1);
        for (int i = 1; i <= 4; i++) begin
            check("drain", int'(byte_data), i);
            step(5'h00, 1'b1);
        end
        check("drain_empty", int'(byte_valid), 0);
        // Full with simultaneous pop
        for (int i = 0; i < 4; i++) begin
            step(5'h16, 1'b0);
            step(5'h18, 1'b0);
        end
        step(5'h1E, 1'b0);
        step(5'h1D, 1'b1);
        check("fullpop_count", int'(fifo_count), 4);
        // Reset mid-pair
        step(5'h00, 1'b0);
        step(5'h1F, 1'b0);
        step(5'h12, 1'b1, 1'b1);
        check("mid_rst_count", int'(fifo_count), 0);
        check("mid_rst_ovf", int'(overflow), 0);
        check("mid_rst_data", int'(byte_data), 0);
        step(5'h16, 1'b0);
        step(5'h17, 1'b0);
        check("post_rst", int'(byte_data), 8'h76);
        // Random phases with varying strobe density and consumer readiness
        for (int p = 0; p < 4; p++) begin
            for (int i = 0; i < 600; i++) begin
                int sp;
                logic [4:0] w;
                sp = (p == 0) ? 50 : (p == 1) ? 15 : (p == 2) ? 4 : 90;
                w[3:0] = 4'($urandom);
                w[4] = ($urandom_range(99) < sp);
                step(w, ($urandom_range(99) < 30 + 20 * p), ($urandom_range(299) == 0));
            end
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/nibble_byte_assembler.md
Name: nibble_byte_assembler

Overview:
- Receive-side stage directly downstream of the 5-bit transmit buffer.
- Consumes the buffered 5-bit link word: bit 4 is the nibble strobe, bits 3:0 are the nibble.
- Pairs nibbles into bytes (low nibble first) and queues them in a small first-word-fall-through FIFO.
- Presents bytes on a valid/ready interface, with gap-timeout realignment and overflow reporting.

Parameters:
- DEPTH, 4, FIFO entries; power of two, at least 2.
- TIMEOUT, 15, idle cycles allowed between the low and high nibble before the held low nibble is discarded; range 1..255.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- rx_word  in  5  link word from the buffer stage; [4] strobe, [3:0] nibble.
- byte_data  out  8  FIFO head byte, {high nibble, low nibble}; valid only while byte_valid=1.
- byte_valid  out  1  FIFO non-empty.
- byte_ready  in  1  consumer accepts the head byte this cycle.
- fifo_count  out  $clog2(DEPTH+1)  number of queued bytes.
- overflow  out  1  sticky; a byte was dropped because the FIFO was full.
- align_error  out  1  one-cycle pulse; a held low nibble was discarded on timeout.

Behaviour:
- Reset (rst=1 at a clk edge):
  - byte_data=0, byte_valid=0, fifo_count=0, overflow=0, align_error=0.
  - FSM goes to LOW, gap counter=0, FIFO pointers=0.
  - Reset overrides any strobe or pop in the same cycle; a partial byte is lost.
- FSM has two states.
  - LOW: on rx_word[4]=1, latch rx_word[3:0] as lo, clear the gap counter, go to HIGH. Strobe=0: stay in LOW.
  - HIGH, strobe=1: form {rx_word[3:0], lo}, issue a push, go to LOW.
  - HIGH, strobe=0: gap counter +1. When the counter reaches TIMEOUT, discard lo, pulse align_error for the next cycle, clear the counter, go to LOW.
  - A strobe arriving in the same cycle the counter would hit TIMEOUT is a valid high nibble; the strobe wins.
- Latency: high nibble sampled at edge N -> byte_valid=1 and byte_data correct after edge N (registered FIFO write, fall-through read).
- FIFO:
  - Pop = byte_valid & byte_ready; the head advances at that edge.
  - Push is accepted when fifo_count<DEPTH, or when fifo_count=DEPTH with a pop in the same cycle.
  - A push with the FIFO full and no pop drops the byte and sets overflow=1 until rst.
  - Simultaneous push and pop: fifo_count unchanged, data order preserved.
  - Pop when empty is ignored; byte_ready is don't-care while byte_valid=0.
  - Pointers are log2(DEPTH) bits and wrap modulo DEPTH; fifo_count is exact, 0..DEPTH.
- byte_data is held stable while byte_valid=1 and byte_ready=0.
- rx_word[3:0] is ignored whenever rx_word[4]=0.

Decomposition:
- Shared package (link_pkg):
  - LINK_W=5
  - STROBE_BIT=4
  - NIBBLE_W=4
  - FSM state encoding {ST_LOW, ST_HIGH}
- One sub-module: sync_fwft_fifo, parameterised on width and DEPTH; provides push/pop/full/empty/count.
- nibble_byte_assembler contains the FSM, gap counter, overflow flag and one FIFO instance.

Test Plan:
- Basic pairing: after reset, rx_word=5'h13 then 5'h1A on consecutive cycles, byte_ready=1 -> byte_data=8'hA3, byte_valid high one cycle, fifo_count 1 then 0.
- Strobe-low words: 5'h15, then 5'h07 (strobe low), then 5'h1C -> single byte 8'hC5; the 4'h7 nibble is ignored; align_error stays 0.
- Timeout at default TIMEOUT=15: 5'h11, then 15 idle cycles -> align_error pulses once. Then 5'h12, 5'h13 -> byte 8'h32, not 8'h21.
- Strobe at the boundary: 5'h14, then 14 idle cycles, then 5'h19 -> byte 8'h94, no align_error.
- Overflow with DEPTH=4, byte_ready=0: push 5 bytes 8'h01..8'h05 -> fifo_count=4, overflow=1. Then drain -> 01,02,03,04 in order; 05 is absent.
- Full plus simultaneous pop, and reset: with FIFO full, byte_ready=1 on the cycle a new byte is pushed -> no drop, overflow unchanged, fifo_count stays 4. Assert rst mid-pair (FSM in HIGH) -> all outputs 0 next cycle, and the next nibble is treated as a low nibble.
